// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: hunts for SYNC_BYTE, collects OP/COUNT/ADDR, checks CRC-8 (poly 0x07) and holds the command until handshake.
// Optional inter-byte gap timeout is built when CMD_RX_TIMEOUT_EN is defined.
module cmd_frame_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA3,
    parameter int         ADDR_BYTES     = 4,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic                    o_rx_ready,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_cmd_valid,
    input  logic                    i_cmd_ready,
    output logic [7:0]              o_cmd_op,
    output logic [7:0]              o_cmd_count,
    output logic [8*ADDR_BYTES-1:0] o_cmd_addr,
    output logic                    o_err_crc,
    output logic                    o_err_timeout
);

    localparam int HDR_LEN = 2 + ADDR_BYTES;
    localparam int AW      = 8 * ADDR_BYTES;

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_HDR  = 2'd1,
        S_CHK  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Serial CRC-8, poly 0x07, init handled by caller, no reflection
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = (c << 1) ^ 8'h07;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [2:0]      idx_r;
    logic [7:0]      crc_r;
    logic [7:0]      crc_nxt_s;
    logic [7:0]      op_sh_r;
    logic [7:0]      count_sh_r;
    logic [AW-1:0]   addr_sh_r;
    logic [7:0]      op_r;
    logic [7:0]      count_r;
    logic [AW-1:0]   addr_r;
    logic            rx_ready_r;
    logic            cmd_valid_r;
    logic            err_crc_r;
    logic            err_to_r;
    logic            accept_s;
    logic            hdr_last_s;
    logic            crc_ok_s;
    logic            timeout_hit_s;

    assign accept_s   = i_rx_valid && rx_ready_r;
    assign hdr_last_s = (idx_r == 3'(HDR_LEN - 1));
    assign crc_nxt_s  = crc8_update(crc_r, i_rx_data);
    assign crc_ok_s   = (i_rx_data == crc_r);

`ifdef CMD_RX_TIMEOUT_EN
    logic [16:0] gap_r;

    assign timeout_hit_s = ((state_r == S_HDR) || (state_r == S_CHK)) && !accept_s &&
                           (gap_r == 17'(TIMEOUT_CYCLES - 1));

    // Gap counter: idle cycles since the last accepted byte inside a frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gap_r <= 17'd0;
        end else if (((state_r == S_HDR) || (state_r == S_CHK)) && !accept_s && !timeout_hit_s) begin
            gap_r <= gap_r + 17'd1;
        end else begin
            gap_r <= 17'd0;
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    assign timeout_hit_s = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= S_HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_HUNT: begin
                if (accept_s && (i_rx_data == SYNC_BYTE)) begin
                    state_nxt_s = S_HDR;
                end else begin
                    state_nxt_s = S_HUNT;
                end
            end
            S_HDR: begin
                if (timeout_hit_s) begin
                    state_nxt_s = S_HUNT;
                end else if (accept_s && hdr_last_s) begin
                    state_nxt_s = S_CHK;
                end else begin
                    state_nxt_s = S_HDR;
                end
            end
            S_CHK: begin
                if (timeout_hit_s) begin
                    state_nxt_s = S_HUNT;
                end else if (accept_s) begin
                    state_nxt_s = crc_ok_s ? S_OUT : S_HUNT;
                end else begin
                    state_nxt_s = S_CHK;
                end
            end
            S_OUT: begin
                if (cmd_valid_r && i_cmd_ready) begin
                    state_nxt_s = S_HUNT;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            default: state_nxt_s = S_HUNT;
        endcase
    end

    // Registered handshake flags and error pulses, derived from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_ready_r  <= 1'b0;
            cmd_valid_r <= 1'b0;
            err_crc_r   <= 1'b0;
            err_to_r    <= 1'b0;
        end else begin
            rx_ready_r  <= (state_nxt_s != S_OUT);
            cmd_valid_r <= (state_nxt_s == S_OUT);
            err_crc_r   <= (state_r == S_CHK) && accept_s && !crc_ok_s && !timeout_hit_s;
            err_to_r    <= timeout_hit_s;
        end
    end

    // Header collection: byte index, running CRC and shadow fields
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_r      <= 3'd0;
            crc_r      <= 8'h00;
            op_sh_r    <= 8'h00;
            count_sh_r <= 8'h00;
            addr_sh_r  <= '0;
        end else begin
            case (state_r)
                S_HUNT: begin
                    if (accept_s && (i_rx_data == SYNC_BYTE)) begin
                        idx_r <= 3'd0;
                        crc_r <= 8'h00;
                    end
                end
                S_HDR: begin
                    if (accept_s) begin
                        crc_r <= crc_nxt_s;
                        idx_r <= idx_r + 3'd1;
                        if (idx_r == 3'd0) begin
                            op_sh_r <= i_rx_data;
                        end
                        if (idx_r == 3'd1) begin
                            count_sh_r <= i_rx_data;
                        end
                        for (int k = 0; k < ADDR_BYTES; k++) begin
                            if (idx_r == 3'(k + 2)) begin
                                addr_sh_r[8*k +: 8] <= i_rx_data;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Command outputs only change when a frame passes its CRC check
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_r    <= 8'h00;
            count_r <= 8'h00;
            addr_r  <= '0;
        end else if ((state_r == S_CHK) && accept_s && crc_ok_s && !timeout_hit_s) begin
            op_r    <= op_sh_r;
            count_r <= count_sh_r;
            addr_r  <= addr_sh_r;
        end
    end

    assign o_rx_ready    = rx_ready_r;
    assign o_cmd_valid   = cmd_valid_r;
    assign o_cmd_op      = op_r;
    assign o_cmd_count   = count_r;
    assign o_cmd_addr    = addr_r;
    assign o_err_crc     = err_crc_r;
    assign o_err_timeout = err_to_r;

endmodule
